cbus_mem_responder: RTL and testbench
=====================================

// Module: cbus_mem_responder
// PURPOSE
//  CBus responder (slave end) backed by an on-chip word RAM. Answers creq/cresp
//  transactions from the CPU-side caches (DCache line fill/writeback, uncached
//  single accesses). Used as the simulation/FPGA memory model behind the caches.
//  Supports single and wrapping bursts, byte-strobed writes and fixed first-beat latency.
// PARAMETERS
//  DEPTH_BITS   12  log2 of RAM depth in 32-bit words; addr[DEPTH_BITS+1:2] indexes RAM
//  LATENCY      2   idle cycles between request acceptance and first beat (0..15)
//  STALL_SEED   8'hA5  LFSR seed, used only with CBUS_RESP_STALL_EN
// PORTS
//  clk     in   1              clock
//  resetn  in   1              synchronous active-low reset
//  creq    in   cbus_req_t     valid,is_write,size,addr,strobe,data,len (common.svh)
//  cresp   out  cbus_resp_t    ready,last,data
//  busy    out  1              transaction in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: resetn synchronous, active-low; clock clk. On reset: state=IDLE,
//    cresp='0, busy=0, beat counter=0. RAM contents not cleared.
//  - Protocol: initiator holds valid,is_write,addr,len,size stable for whole
//    transaction; responder asserts ready for exactly one cycle per beat;
//    last=1 with the final beat. Beats = len+1 (MLEN1=1,MLEN2=2,MLEN4=4,
//    MLEN8=8,MLEN16=16).
//  - Beat address: word index = {addr[hi:2] with low log2(beats) bits replaced
//    by (addr low bits + beat_cnt) mod beats}, i.e. wrapping burst within the
//    len-aligned block (critical-word-first). Index taken modulo 2^DEPTH_BITS.
//  - FSM: IDLE -> (creq.valid) latch addr/len/is_write, cnt=0 -> WAIT
//    (LATENCY cycles; LATENCY=0 skips WAIT) -> BEAT.
//    BEAT: each cycle ready=1 is a beat; cnt++; beat with cnt==len has last=1,
//    next state IDLE. ready/last/data are registered outputs.
//  - Read: cresp.data = RAM[beat addr] in the same cycle ready=1; RAM read
//    issued one cycle earlier (registered). data=0 when ready=0.
//  - Write: in each cycle ready=1, RAM[beat addr] byte lanes with creq.strobe[i]=1
//    take creq.data[8i+7:8i]; initiator advances data on the cycle after ready.
//    cresp.data=0 for writes.
//  - size field ignored: full-word access; byte selection via strobe only.
//  - Back-to-back: IDLE re-samples creq.valid the cycle after last; a request
//    held valid then is accepted with no extra gap beyond LATENCY.
//  - Abort: creq.valid low while in WAIT/BEAT -> IDLE next cycle, no further
//    RAM writes, ready/last low from next cycle.
//  - Reset mid-transaction: returns to IDLE immediately; partial write beats
//    already committed remain in RAM.
//  - Latched len/addr used for entire burst; changes to creq mid-burst ignored
//    except creq.data/strobe (write) and creq.valid (abort).
// CONFIGURATION
//  CBUS_RESP_STALL_EN defined: 8-bit LFSR (seed STALL_SEED, taps 8,6,5,4)
//    steps every cycle; in BEAT, if lfsr[0]==1 the beat is withheld (ready=0,
//    cnt unchanged). Exercises initiator wait-tolerance.
//  Not defined: no LFSR logic; BEAT emits one beat per cycle, no gaps.
// TESTING
//  1 Single read: RAM[0x10>>2]=32'hDEADBEEF; creq read addr=0x10 len=MLEN1 ->
//    ready=last=1 exactly LATENCY+1 cycles after valid, data=DEADBEEF.
//  2 Wrapping fill: RAM words 0x40..0x4C = 1,2,3,4; read addr=0x48 len=MLEN4 ->
//    beats data 3,4,1,2 on consecutive cycles, last only on 4th.
//  3 Strobed write: RAM[0x20]=32'h11223344; write addr=0x20 len=MLEN1
//    strobe=4'b0101 data=32'hAABBCCDD -> readback 32'h11BB33DD.
//  4 Writeback then fill: write burst addr=0x80 MLEN4 data 5,6,7,8, valid drops
//    one cycle after last, read MLEN4 addr=0x80 next cycle -> data 5,6,7,8.
//  5 Abort: read MLEN4, drop valid after 2nd beat -> no 3rd ready, busy=0 next
//    cycle; following MLEN1 read responds normally.
//  6 CBUS_RESP_STALL_EN: random MLEN16 reads/writes vs scoreboard -> exactly
//    16 ready pulses, one last, data matches model.

Source files
------------

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: CBus responder backed by an on-chip word RAM.
// Serves single and wrapping (critical-word-first) bursts with fixed first-beat
// latency and byte-strobed writes. Optional random beat stalls: CBUS_RESP_STALL_EN.

package cbus_pkg;
  localparam int unsigned CBUS_AW = 32;
  localparam int unsigned CBUS_DW = 32;
  localparam int unsigned CBUS_SW = CBUS_DW / 8;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    logic [1:0]         size;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_SW-1:0] strobe;
    logic [CBUS_DW-1:0] data;
    cbus_len_t          len;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;
endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [7:0]  STALL_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);

  localparam int unsigned DEPTH  = 1 << DEPTH_BITS;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DW     = CBUS_DW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  last_q, last_d;
  logic [DW-1:0]         data_q, data_d;
  logic [DEPTH_BITS-1:0] idx_q, idx_d;
  logic                  busy_q, busy_d;

  logic [DEPTH_BITS-1:0] base_c, mask_c, iss_idx_c;
  logic [CNT_W-1:0]      len_c, iss_cnt_c;
  logic                  we_c, issue_c, stall_c, wr_en_c;
  logic [DW-1:0]         rd_c;
  logic                  unused_c;

`ifdef CBUS_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running LFSR (taps 8,6,5,4); low bit withholds the next beat
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    stall_c = lfsr_q[0];
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= STALL_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign unused_c = ^{creq.size, creq.addr[CBUS_AW-1:DEPTH_BITS+2], creq.addr[1:0]};
`else
  assign stall_c  = 1'b0;
  assign unused_c = ^{creq.size, creq.addr[CBUS_AW-1:DEPTH_BITS+2], creq.addr[1:0], STALL_SEED};
`endif

  // Beat address: wrap within the len-aligned block; IDLE issues straight from creq
  always_comb begin
    base_c    = (state_q == S_IDLE) ? creq.addr[DEPTH_BITS+1:2] : addr_q;
    len_c     = (state_q == S_IDLE) ? creq.len : len_q;
    we_c      = (state_q == S_IDLE) ? creq.is_write : we_q;
    iss_cnt_c = (state_q == S_IDLE) ? '0 : cnt_q;
    mask_c    = DEPTH_BITS'(len_c);
    iss_idx_c = (base_c & ~mask_c) | ((base_c + DEPTH_BITS'(iss_cnt_c)) & mask_c);
    rd_c      = mem[iss_idx_c];
  end

  // Next-state and registered-output logic; a beat is issued one cycle before it is presented
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    we_d    = we_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    last_d  = 1'b0;
    data_d  = '0;
    issue_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (creq.valid) begin
          addr_d = creq.addr[DEPTH_BITS+1:2];
          len_d  = creq.len;
          we_d   = creq.is_write;
          cnt_d  = '0;
          if (LATENCY == 0) begin
            state_d = S_BEAT;
            issue_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (wait_q == '0) begin
          state_d = S_BEAT;
          issue_c = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_BEAT: begin
        if (!creq.valid || (ready_q && last_q)) state_d = S_IDLE;
        else                                    issue_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue_c && !stall_c) begin
      ready_d = 1'b1;
      last_d  = (iss_cnt_c == len_c);
      data_d  = we_c ? '0 : rd_c;
      idx_d   = iss_idx_c;
      cnt_d   = iss_cnt_c + CNT_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Write commits on each presented write beat while the initiator still holds valid
  assign wr_en_c = resetn && (state_q == S_BEAT) && ready_q && we_q && creq.valid;

  // Byte-strobed RAM write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(CBUS_SW); i++) begin
      if (wr_en_c && creq.strobe[i]) mem[idx_q][8*i +: 8] <= creq.data[8*i +: 8];
    end
  end

  assign cresp = '{ready: ready_q, last: last_q, data: data_q};
  assign busy  = busy_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Scoreboard bench for cbus_mem_responder: the driver queues expected beats,
// a negedge monitor pops one per ready and compares data/last.
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       busy;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] vals [16];
  int          checks = 0;
  int          errors = 0;

  cbus_mem_responder #(.DEPTH_BITS(12), .LATENCY(LAT), .STALL_SEED(8'hA5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .creq   (creq),
    .cresp  (cresp),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every presented beat must match the next queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && cresp.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got ready=1 data=%h, required no beat (t=%0t)", cresp.data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", cresp.data, mon_e.data);
        check("beat_last", 32'(cresp.last), 32'(mon_e.last));
      end
    end
  end

  // One transaction; stop_after>0 drops valid during that beat (abort)
  task automatic txn(input logic we, input logic [31:0] addr, input cbus_len_t len,
                     input logic [3:0] strb, input int stop_after);
    int   beats = int'(len) + 1;
    int   nexp  = (stop_after > 0) ? stop_after : beats;
    int   k     = 0;
    int   seen  = 0;
    int   cyc   = 0;
    logic prev  = 1'b0;
    for (int i = 0; i < nexp; i++)
      exp_q.push_back('{data: (we ? 32'h0 : vals[i]), last: (i == beats - 1)});
    @(posedge clk); #1;
    creq.valid    = 1'b1;
    creq.is_write = we;
    creq.size     = 2'b10;
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.len      = len;
    creq.data     = vals[0];
    while (seen < nexp && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (prev && k < 15) begin
        k++;
        creq.data = vals[k];
      end
      prev = cresp.ready;
      if (cresp.ready === 1'b1) begin
`ifndef CBUS_RESP_STALL_EN
        if (seen == 0) check("first_beat_latency", 32'(cyc), 32'(LAT + 1));
`endif
        seen++;
        if (stop_after > 0 && seen == stop_after) creq.valid = 1'b0;
      end
    end
    if (seen < nexp) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", seen, nexp);
    end
`ifndef CBUS_RESP_STALL_EN
    if (stop_after == 0) check("burst_span", 32'(cyc), 32'(LAT + nexp));
`endif
    @(posedge clk); #1;
    creq.valid = 1'b0;
    check("busy_after", 32'(busy), 32'h0);
    check("ready_after", 32'(cresp.ready), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    creq   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(cresp.ready), 32'h0);
    check("reset_last", 32'(cresp.last), 32'h0);
    check("reset_data", cresp.data, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    resetn = 1'b1;

    // Single read
    vals[0] = 32'hDEADBEEF;
    txn(1'b1, 32'h10, MLEN1, 4'hF, 0);
    txn(1'b0, 32'h10, MLEN1, 4'hF, 0);

    // Wrapping fill, critical word first
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd4;
    txn(1'b1, 32'h40, MLEN4, 4'hF, 0);
    vals[0] = 32'd3; vals[1] = 32'd4; vals[2] = 32'd1; vals[3] = 32'd2;
    txn(1'b0, 32'h48, MLEN4, 4'hF, 0);
    vals[0] = 32'd2; vals[1] = 32'd1;
    txn(1'b0, 32'h44, MLEN2, 4'hF, 0);

    // Strobed write
    vals[0] = 32'h11223344;
    txn(1'b1, 32'h20, MLEN1, 4'hF, 0);
    vals[0] = 32'hAABBCCDD;
    txn(1'b1, 32'h20, MLEN1, 4'b0101, 0);
    vals[0] = 32'h11BB33DD;
    txn(1'b0, 32'h20, MLEN1, 4'hF, 0);

    // Writeback then fill
    vals[0] = 32'd5; vals[1] = 32'd6; vals[2] = 32'd7; vals[3] = 32'd8;
    txn(1'b1, 32'h80, MLEN4, 4'hF, 0);
    txn(1'b0, 32'h80, MLEN4, 4'hF, 0);

    // Abort after second beat, then a normal single read
    txn(1'b0, 32'h80, MLEN4, 4'hF, 2);
    vals[0] = 32'hDEADBEEF;
    txn(1'b0, 32'h10, MLEN1, 4'hF, 0);

    // Address wraps modulo RAM depth (16 KiB)
    vals[0] = 32'hCAFEF00D;
    txn(1'b1, 32'h4010, MLEN1, 4'hF, 0);
    txn(1'b0, 32'h10, MLEN1, 4'hF, 0);

    // 16-beat write, then 16-beat wrapping read starting mid-block
    for (int i = 0; i < 16; i++) vals[i] = 32'h1000 + 32'(i);
    txn(1'b1, 32'h100, MLEN16, 4'hF, 0);
    for (int i = 0; i < 16; i++) vals[i] = 32'h1000 + 32'((i + 8) % 16);
    txn(1'b0, 32'h120, MLEN16, 4'hF, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
